bitwise_reduce_unit: RTL and testbench

- Parametrised, registered successor to the team's combinational two-input AND gate.
- Applies a selectable bitwise operation (AND/OR/XOR/NAND) to WIDTH-bit operands in one of two modes:
  - PAIR: one result per input beat, f = a op b.
  - REDUCE: folds a multi-beat burst of a into one result.
- Inputs use valid/ready handshakes, results use a single registered output stage. Sits between a stimulus source (switches/FIFO) and a display/consumer stage.

---
 rtl/bitwise_reduce_unit.sv | 183 ++++++++++++++++++
 tb/tb_bitwise_reduce_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_reduce_unit.sv
// Registered bitwise AND/OR/XOR/NAND unit with per-beat PAIR results and
// multi-beat REDUCE folding, valid/ready on both sides.
module bitwise_reduce_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [CNT_W-1:0] beats,
  output logic             zero
);

  localparam logic [1:0] OP_AND      = 2'd0;
  localparam logic [1:0] OP_OR       = 2'd1;
  localparam logic [1:0] OP_XOR      = 2'd2;
  localparam logic [1:0] OP_NAND     = 2'd3;
  localparam logic       MODE_PAIR   = 1'b0;
  localparam logic       MODE_REDUCE = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  // NAND folds as AND; its inversion is applied only when a result is produced.
  function automatic logic [WIDTH-1:0] fold_op(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = x & y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] finish_op(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] x);
    return (sel == OP_NAND) ? ~x : x;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             zero_q, zero_d;

  logic             accept_s;
  logic             load_s;
  logic [WIDTH-1:0] result_s;
  logic [CNT_W-1:0] result_beats_s;
  logic [WIDTH-1:0] fold_s;

  assign in_ready  = ~out_valid_q | out_ready;
  assign accept_s  = in_valid & in_ready;
  assign fold_s    = fold_op(op_q, acc_q, a);
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign beats     = beats_q;
  assign zero      = zero_q;

  // Burst state machine: decides what an accepted beat does and whether it yields a result.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    mode_d         = mode_q;
    load_s         = 1'b0;
    result_s       = f_q;
    result_beats_s = beats_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d   = op;
          mode_d = mode;
          if (mode == MODE_PAIR) begin
            load_s         = 1'b1;
            result_s       = finish_op(op, fold_op(op, a, b));
            result_beats_s = CNT_ONE;
          end else if (in_last) begin
            load_s         = 1'b1;
            result_s       = finish_op(op, a);
            result_beats_s = CNT_ONE;
          end else begin
            acc_d   = a;
            cnt_d   = CNT_ONE;
            state_d = S_ACC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        // op/mode inputs are ignored here; the values latched at burst start rule.
        if (mode_q != MODE_REDUCE) begin
          state_d = S_IDLE;
        end else if (accept_s) begin
          if (in_last) begin
            load_s         = 1'b1;
            result_s       = finish_op(op_q, fold_s);
            result_beats_s = sat_inc(cnt_q);
            state_d        = S_IDLE;
          end else begin
            acc_d   = fold_s;
            cnt_d   = sat_inc(cnt_q);
            state_d = S_ACC;
          end
        end else begin
          state_d = S_ACC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output stage: a new result overrides consumption, so back-to-back results keep out_valid high.
  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    f_d         = f_q;
    beats_d     = beats_q;
    zero_d      = zero_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      f_d         = result_s;
      beats_d     = result_beats_s;
      zero_d      = (result_s == {WIDTH{1'b0}});
    end else begin
      f_d = f_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      op_q        <= 2'd0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= {WIDTH{1'b0}};
      beats_q     <= {CNT_W{1'b0}};
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      beats_q     <= beats_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_bitwise_reduce_unit.sv
// Self-checking bench for bitwise_reduce_unit: directed scenarios plus random
// traffic compared against a burst-level reference model.
module tb_bitwise_reduce_unit;

  logic       clk = 1'b0;
  logic       reset, mode, in_valid, in_ready, in_last, out_valid, out_ready, zero;
  logic [1:0] op;
  logic [7:0] a, b, f, beats;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic       m_valid, m_zero, m_in_burst;
  logic [7:0] m_f, m_beats;
  logic [1:0] m_op;
  logic [7:0] m_q[$];
  logic       obs_rdy, exp_rdy;

  bitwise_reduce_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .beats(beats), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_pair(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'd0: return x & y;
      2'd1: return x | y;
      2'd2: return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Reduction over the whole collected burst; NAND is the inverted AND of every beat.
  function automatic logic [7:0] ref_reduce(input logic [1:0] o);
    logic [7:0] r;
    r = (o == 2'd0 || o == 2'd3) ? 8'hFF : 8'h00;
    for (int i = 0; i < m_q.size(); i++) begin
      case (o)
        2'd1: r = r | m_q[i];
        2'd2: r = r ^ m_q[i];
        default: r = r & m_q[i];
      endcase
    end
    return (o == 2'd3) ? ~r : r;
  endfunction

  task automatic produce(input logic [7:0] val, input int n);
    m_valid = 1'b1;
    m_f     = val;
    m_beats = (n > 255) ? 8'd255 : 8'(n);
    m_zero  = (val == 8'h00);
  endtask

  task automatic model_step(input logic r, input logic v, input logic [1:0] o, input logic md,
                            input logic [7:0] aa, input logic [7:0] bb, input logic lst, input logic ordy);
    logic acc;
    if (r) begin
      m_valid = 1'b0; m_f = 8'h00; m_beats = 8'h00; m_zero = 1'b0;
      m_in_burst = 1'b0; m_q.delete(); m_op = 2'd0;
    end else begin
      acc = v & (~m_valid | ordy);
      if (m_valid & ordy) m_valid = 1'b0;
      if (acc) begin
        if (!m_in_burst) begin
          m_op = o;
          if (md == 1'b0) begin
            produce(ref_pair(o, aa, bb), 1);
          end else begin
            m_q.delete();
            m_q.push_back(aa);
            if (lst) begin
              produce(ref_reduce(m_op), m_q.size());
            end else begin
              m_in_burst = 1'b1;
            end
          end
        end else begin
          m_q.push_back(aa);
          if (lst) begin
            produce(ref_reduce(m_op), m_q.size());
            m_in_burst = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [1:0] o, input logic md,
                       input logic [7:0] aa, input logic [7:0] bb, input logic lst, input logic ordy);
    reset = r; in_valid = v; op = o; mode = md; a = aa; b = bb; in_last = lst; out_ready = ordy;
    #1;
    obs_rdy = in_ready;
    exp_rdy = ~m_valid | ordy;
    @(posedge clk);
    model_step(r, v, o, md, aa, bb, lst, ordy);
    #1;
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (f !== 8'h00) begin failures++; $display("FAIL reset_f got=%h exp=00", f); end
    checks++; if (beats !== 8'h00) begin failures++; $display("FAIL reset_beats got=%h exp=00", beats); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero); end
    checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", obs_rdy); end
  endtask

  task automatic test_pair_stream;
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || f !== 8'h30 || beats !== 8'd1 || zero !== 1'b0) begin
      failures++; $display("FAIL pair_and_1 got v=%b f=%h beats=%0d z=%b exp v=1 f=30 beats=1 z=0", out_valid, f, beats, zero); end
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || f !== 8'h00 || beats !== 8'd1 || zero !== 1'b1) begin
      failures++; $display("FAIL pair_and_2 got v=%b f=%h beats=%0d z=%b exp v=1 f=00 beats=1 z=1", out_valid, f, beats, zero); end
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pair_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_pair_nand_xor;
    cycle(1'b0, 1'b1, 2'd3, 1'b0, 8'hAA, 8'hFF, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || f !== 8'h55) begin
      failures++; $display("FAIL pair_nand got v=%b f=%h exp v=1 f=55", out_valid, f); end
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 8'hAA, 8'hFF, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || f !== 8'h55 || zero !== 1'b0) begin
      failures++; $display("FAIL pair_xor got v=%b f=%h z=%b exp v=1 f=55 z=0", out_valid, f, zero); end
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reduce_or;
    cycle(1'b0, 1'b1, 2'd1, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reduce_beat1_valid got=%b exp=0", out_valid); end
    cycle(1'b0, 1'b1, 2'd0, 1'b1, 8'h02, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reduce_beat2_valid got=%b exp=0", out_valid); end
    cycle(1'b0, 1'b1, 2'd0, 1'b1, 8'h80, 8'h00, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || f !== 8'h83 || beats !== 8'd3) begin
      failures++; $display("FAIL reduce_or got v=%b f=%h beats=%0d exp v=1 f=83 beats=3", out_valid, f, beats); end
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reduce_single_pulse got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 8'h3C, 8'hFF, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || f !== 8'h3C) begin
      failures++; $display("FAIL bp_load got v=%b f=%h exp v=1 f=3c", out_valid, f); end
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", obs_rdy); end
    checks++; if (out_valid !== 1'b1 || f !== 8'h3C || zero !== 1'b0) begin
      failures++; $display("FAIL bp_hold got v=%b f=%h z=%b exp v=1 f=3c z=0", out_valid, f, zero); end
    cycle(1'b0, 1'b1, 2'd0, 1'b0, 8'h0F, 8'hFF, 1'b0, 1'b1);
    checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", obs_rdy); end
    checks++; if (out_valid !== 1'b1 || f !== 8'h0F) begin
      failures++; $display("FAIL bp_back_to_back got v=%b f=%h exp v=1 f=0f", out_valid, f); end
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_burst;
    cycle(1'b0, 1'b1, 2'd2, 1'b1, 8'h11, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 2'd2, 1'b1, 8'h22, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 2'd2, 1'b1, 8'h44, 8'h00, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || f !== 8'h44 || beats !== 8'd1) begin
      failures++; $display("FAIL reset_mid_burst got v=%b f=%h beats=%0d exp v=1 f=44 beats=1", out_valid, f, beats); end
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_saturation;
    logic [7:0] orv;
    logic [7:0] d;
    orv = 8'h00;
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom_range(0, 255)) & 8'h3F;
      orv = orv | d;
      cycle(1'b0, 1'b1, 2'd1, 1'b1, d, 8'h00, (i == 299), 1'b1);
      if (i < 299) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_early_valid beat=%0d got=%b exp=0", i, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1 || beats !== 8'd255 || f !== orv) begin
      failures++; $display("FAIL sat_result got v=%b f=%h beats=%0d exp v=1 f=%h beats=255", out_valid, f, beats, orv); end
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic       r, v, md, lst, ordy;
    logic [1:0] o;
    logic [7:0] aa, bb;
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 63) == 0);
      v    = ($urandom_range(0, 3) != 0);
      o    = 2'($urandom_range(0, 3));
      md   = 1'($urandom_range(0, 1));
      lst  = ($urandom_range(0, 2) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      aa   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      bb   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      cycle(r, v, o, md, aa, bb, lst, ordy);
      checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, obs_rdy, exp_rdy); end
      checks++; if (out_valid !== m_valid || f !== m_f || beats !== m_beats || zero !== m_zero) begin
        failures++;
        $display("FAIL rand_out n=%0d got v=%b f=%h beats=%0d z=%b exp v=%b f=%h beats=%0d z=%b",
                 n, out_valid, f, beats, zero, m_valid, m_f, m_beats, m_zero);
      end
    end
  endtask

  initial begin
    m_valid = 1'b0; m_f = 8'h00; m_beats = 8'h00; m_zero = 1'b0; m_in_burst = 1'b0; m_op = 2'd0;
    test_reset();
    test_pair_stream();
    test_pair_nand_xor();
    test_reduce_or();
    test_backpressure();
    test_reset_mid_burst();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
